// File: rtl/flopbank.sv
// flopbank: CHANNELS independent enabled register chains, WIDTH bits by DEPTH stages, with valid tracking.
// Build option FLOPBANK_PARITY_EN adds per-stage even parity and a sticky per-channel perr flag.

module flopbank_lane #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             flush_i,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             valid_o,
   output logic             perr_o
);

   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
   logic                        clr;

   // Reset and flush have identical effect; reset merely has higher priority.
   assign clr = !reset_ni || flush_i;

   always_comb begin
      data_d     = data_q;
      vld_pipe_d = vld_pipe_q;
      if (en_i) begin
         data_d[0]     = d_i;
         vld_pipe_d[0] = valid_i;
         for (int k = 1; k < DEPTH; k++) begin
            data_d[k]     = data_q[k-1];
            vld_pipe_d[k] = vld_pipe_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         data_q     <= {DEPTH{RESET_VAL}};
         vld_pipe_q <= '0;
      end else begin
         data_q     <= data_d;
         vld_pipe_q <= vld_pipe_d;
      end
   end

   assign q_o     = data_q[DEPTH-1];
   assign valid_o = vld_pipe_q[DEPTH-1];

`ifdef FLOPBANK_PARITY_EN
   logic [DEPTH-1:0] par_q, par_d;
   logic             perr_q, perr_d;

   // Stored bit makes {data, par} XOR to zero; checked only while the output slot is valid.
   always_comb begin
      par_d = par_q;
      if (en_i) begin
         par_d[0] = ^d_i;
         for (int k = 1; k < DEPTH; k++) par_d[k] = par_q[k-1];
      end
      perr_d = perr_q | (vld_pipe_q[DEPTH-1] & (^{data_q[DEPTH-1], par_q[DEPTH-1]}));
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         par_q  <= '0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign perr_o = perr_q;
`else
   assign perr_o = 1'b0;
`endif

endmodule

module flopbank #(
   parameter int               WIDTH     = 32,
   parameter int               CHANNELS  = 2,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       valid_in,
   input  logic [CHANNELS*WIDTH-1:0] d,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [CHANNELS-1:0]       valid_out,
   output logic [CHANNELS-1:0]       perr
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      flopbank_lane #(
         .WIDTH     (WIDTH),
         .DEPTH     (DEPTH),
         .RESET_VAL (RESET_VAL)
      ) u_lane (
         .clk_i    (clk),
         .reset_ni (reset_n),
         .flush_i  (flush),
         .en_i     (en[c]),
         .valid_i  (valid_in[c]),
         .d_i      (d[c*WIDTH +: WIDTH]),
         .q_o      (q[c*WIDTH +: WIDTH]),
         .valid_o  (valid_out[c]),
         .perr_o   (perr[c])
      );
   end

endmodule

// File: tb/tb_flopbank.sv
// Bench for flopbank: three depths side by side, table vectors, corner sequences, random vs history model.
module tb_flopbank;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  en = '0, vin = '0;
   logic [31:0] d0 = '0, d1 = '0;
   logic [63:0] q1, q2, q3;
   logic [1:0]  v1, v2, v3, p1, p2, p3;

   always #5 clk = ~clk;

   flopbank #(.WIDTH(32), .CHANNELS(2), .DEPTH(1), .RESET_VAL(32'h0)) dut_d1 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .en(en), .valid_in(vin),
      .d({d1, d0}), .q(q1), .valid_out(v1), .perr(p1));
   flopbank #(.WIDTH(32), .CHANNELS(2), .DEPTH(2), .RESET_VAL(32'h1234_5678)) dut_d2 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .en(en), .valid_in(vin),
      .d({d1, d0}), .q(q2), .valid_out(v2), .perr(p2));
   flopbank #(.WIDTH(32), .CHANNELS(2), .DEPTH(3), .RESET_VAL(32'h0)) dut_d3 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .en(en), .valid_in(vin),
      .d({d1, d0}), .q(q3), .valid_out(v3), .perr(p3));

   int vectors = 0, miscompares = 0;
   bit chk_perr = 1'b1;

   // Model: per-channel list of enabled captures since the last clear; q is DEPTH entries back.
   logic [32:0] hist [2][0:4095];
   int          n [2];

   function automatic logic [31:0] rv(int dep);
      return (dep == 2) ? 32'h1234_5678 : 32'h0;
   endfunction

   function automatic logic [32:0] ref_out(int c, int dep);
      if (n[c] >= dep) return hist[c][n[c]-dep];
      return {1'b0, rv(dep)};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      if (!reset_n || flush) begin
         n[0] = 0;
         n[1] = 0;
      end else begin
         for (int c = 0; c < 2; c++)
            if (en[c]) begin
               hist[c][n[c]] = {vin[c], (c == 1) ? d1 : d0};
               n[c]++;
            end
      end
   endtask

   task automatic check_model();
      logic [32:0] e;
      logic [63:0] qa;
      logic [1:0]  va, pa;
      for (int dep = 1; dep <= 3; dep++) begin
         case (dep)
            1:       begin qa = q1; va = v1; pa = p1; end
            2:       begin qa = q2; va = v2; pa = p2; end
            default: begin qa = q3; va = v3; pa = p3; end
         endcase
         for (int c = 0; c < 2; c++) begin
            e = ref_out(c, dep);
            chk($sformatf("model_d%0d_q%0d", dep, c), {32'h0, qa[c*32 +: 32]}, {32'h0, e[31:0]});
            chk($sformatf("model_d%0d_v%0d", dep, c), {63'h0, va[c]}, {63'h0, e[32]});
         end
         if (chk_perr) chk($sformatf("model_d%0d_perr", dep), {62'h0, pa}, 64'h0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   typedef struct {
      bit          rst_n;
      bit          fl;
      bit [1:0]    en;
      bit [1:0]    vin;
      logic [31:0] d0, d1;
      logic [31:0] e0, e1;
      bit [1:0]    ev;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [1:0] exp_perr;
      n[0] = 0;
      n[1] = 0;
      // Expected values are for the DEPTH=3 instance after the edge of each row.
      tbl[0]  = '{0, 0, 2'b11, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0,  2'b00};
      tbl[1]  = '{0, 0, 2'b11, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0,  2'b00};
      tbl[2]  = '{1, 0, 2'b11, 2'b11, 32'h1,  32'h10, 32'h0, 32'h0,  2'b00};
      tbl[3]  = '{1, 0, 2'b11, 2'b11, 32'h2,  32'h20, 32'h0, 32'h0,  2'b00};
      tbl[4]  = '{1, 0, 2'b11, 2'b11, 32'h3,  32'h30, 32'h1, 32'h10, 2'b11};
      tbl[5]  = '{1, 0, 2'b11, 2'b11, 32'h4,  32'h40, 32'h2, 32'h20, 2'b11};
      tbl[6]  = '{1, 0, 2'b00, 2'b11, 32'hFF, 32'hFF, 32'h2, 32'h20, 2'b11};
      tbl[7]  = '{1, 0, 2'b11, 2'b11, 32'h5,  32'h50, 32'h3, 32'h30, 2'b11};
      tbl[8]  = '{1, 0, 2'b01, 2'b11, 32'h6,  32'h60, 32'h4, 32'h30, 2'b11};
      tbl[9]  = '{1, 1, 2'b11, 2'b11, 32'h55, 32'h55, 32'h0, 32'h0,  2'b00};
      tbl[10] = '{1, 0, 2'b11, 2'b01, 32'h7,  32'h70, 32'h0, 32'h0,  2'b00};
      tbl[11] = '{1, 0, 2'b11, 2'b01, 32'h8,  32'h80, 32'h0, 32'h0,  2'b00};
      tbl[12] = '{1, 0, 2'b11, 2'b01, 32'h9,  32'h90, 32'h7, 32'h70, 2'b01};

      for (int i = 0; i < 13; i++) begin
         reset_n = tbl[i].rst_n; flush = tbl[i].fl; en = tbl[i].en; vin = tbl[i].vin;
         d0 = tbl[i].d0; d1 = tbl[i].d1;
         step();
         chk($sformatf("tbl%0d_q0", i), {32'h0, q3[31:0]},  {32'h0, tbl[i].e0});
         chk($sformatf("tbl%0d_q1", i), {32'h0, q3[63:32]}, {32'h0, tbl[i].e1});
         chk($sformatf("tbl%0d_v", i),  {62'h0, v3},        {62'h0, tbl[i].ev});
      end

      // Independent enable on the DEPTH=1 instance.
      reset_n = 1'b0; flush = 1'b0; en = 2'b00; step();
      reset_n = 1'b1; en = 2'b01; vin = 2'b11; d0 = 32'hDEADBEEF; d1 = 32'hCAFEF00D; step();
      chk("indep_q0", {32'h0, q1[31:0]},  64'hDEADBEEF);
      chk("indep_q1", {32'h0, q1[63:32]}, 64'h0);

      // Mid-pipe stall on the DEPTH=2 instance.
      flush = 1'b1; step(); flush = 1'b0;
      en = 2'b01; d0 = 32'h11; step();
      d0 = 32'h22; step();
      chk("stall_load", {32'h0, q2[31:0]}, 64'h11);
      en = 2'b00; d0 = 32'h33;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall_hold%0d", i), {32'h0, q2[31:0]}, 64'h11);
      end
      en = 2'b01; d0 = 32'h44; step();
      chk("stall_resume", {32'h0, q2[31:0]}, 64'h22);

      // Parity error on ch1 of the DEPTH=1 instance; flipping the stored parity bit
      // is equivalent to flipping a data bit for the checker.
      en = 2'b11; vin = 2'b11; d0 = 32'h0; d1 = 32'h0F; step();
      en = 2'b00;
`ifdef FLOPBANK_PARITY_EN
      chk_perr = 1'b0;
      exp_perr = 2'b10;
      force dut_d1.g_ch[1].u_lane.par_q = 1'b1;
`else
      exp_perr = 2'b00;
`endif
      step();
      chk("perr_set", {62'h0, p1}, {62'h0, exp_perr});
`ifdef FLOPBANK_PARITY_EN
      release dut_d1.g_ch[1].u_lane.par_q;
`endif
      step();
      chk("perr_sticky", {62'h0, p1}, {62'h0, exp_perr});
      flush = 1'b1; step(); flush = 1'b0;
      chk("perr_flush", {62'h0, p1}, 64'h0);
      chk_perr = 1'b1;

      for (int i = 0; i < 1000; i++) begin
         reset_n = ($urandom_range(0, 31) != 0);
         flush   = ($urandom_range(0, 15) == 0);
         en      = 2'($urandom);
         vin     = 2'($urandom);
         d0      = $urandom;
         d1      = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
